// File: rtl/wb_merge.sv
// wb_merge: merges the in-order pipeline writeback stream and out-of-order
// multi-cycle results onto the single register-file write port.
//
// The pipeline always wins the write slot. Multi-cycle results wait in a
// small circular FIFO and drain into idle slots. When the FIFO is empty and
// the slot is free, a result goes straight through. A pipeline write to
// register A kills every queued result for A. The killed entry keeps its
// slot and later pops without writing. This preserves WAW ordering.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   pipe_w    - pipeline write request {en, addr, wd}; never stalled
//   mdu_valid - multi-cycle result valid
//   mdu_addr  - multi-cycle result destination register
//   mdu_data  - multi-cycle result data
//   mdu_ready - FIFO can accept a result this cycle
//   w         - registered write request to the regfile {en, addr, wd}
//   ra1, ra2  - decode source addresses for the busy query
//   busy1/2   - a live queued write targets ra1/ra2
//   count     - current FIFO occupancy
//
// Handshake: a result transfers on a cycle where mdu_valid && mdu_ready.
// mdu_ready depends only on registered occupancy. The producer must hold
// addr/data stable while valid is high and ready is low.
module wb_merge #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW+DW:0]           pipe_w,
    input  logic                     mdu_valid,
    input  logic [AW-1:0]            mdu_addr,
    input  logic [DW-1:0]            mdu_data,
    output logic                     mdu_ready,
    output logic [AW+DW:0]           w,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     busy1,
    output logic                     busy2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW+DW:0]   w_q, w_d;

    logic          pipe_en;
    logic [AW-1:0] pipe_addr;
    logic          pipe_own;
    logic          fifo_empty;
    logic          xfer_nz;
    logic          pop;
    logic          bypass;
    logic          push;

    assign pipe_en   = pipe_w[AW+DW];
    assign pipe_addr = pipe_w[AW+DW-1:DW];
    // A pipeline request to r0 is treated as an idle slot.
    assign pipe_own  = pipe_en && (pipe_addr != '0);

    assign mdu_ready  = (count_q < DEPTH_C);
    assign fifo_empty = (count_q == '0);
    // Accepted transfers to r0 are swallowed here.
    assign xfer_nz    = mdu_valid && mdu_ready && (mdu_addr != '0);
    assign pop        = !pipe_own && !fifo_empty;
    // Bypass only when nothing older is queued. It never applies while the
    // pipeline owns the slot, so a same-address result cannot slip past.
    assign bypass     = !pipe_own && fifo_empty && xfer_nz;
    assign push       = xfer_nz && !bypass;

    always_comb begin
        w_d = '0;
        if (pipe_own) begin
            w_d = pipe_w;
        end else if (pop) begin
            // A dead head uses up the free slot but does not write.
            if (live_q[head_q]) begin
                w_d = {1'b1, addr_q[head_q], data_q[head_q]};
            end
        end else if (bypass) begin
            w_d = {1'b1, mdu_addr, mdu_data};
        end
    end

    always_comb begin
        live_d = live_q;
        // A pipeline write is younger than everything queued.
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_own && (addr_q[i] == pipe_addr)) begin
                live_d[i] = 1'b0;
            end
        end
        // Clear freed slots so they cannot contribute to busy.
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        // push and pop never share an index: head==tail only when empty or full.
        if (push) begin
            live_d[tail_q] = !(pipe_own && (mdu_addr == pipe_addr));
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q     <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            w_q     <= w_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            if (push) begin
                addr_q[tail_q] <= mdu_addr;
                data_q[tail_q] <= mdu_data;
            end
        end
    end

    // The in-flight w and the incoming transfer are excluded. The regfile
    // bypasses w itself.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == ra1)) busy1 = 1'b1;
            if (live_q[i] && (addr_q[i] == ra2)) busy2 = 1'b1;
        end
        if (ra1 == '0) busy1 = 1'b0;
        if (ra2 == '0) busy2 = 1'b0;
    end

    assign w     = w_q;
    assign count = count_q;

endmodule

// File: tb/tb_wb_merge.sv
module tb_wb_merge;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int W     = AW + DW + 1;

    logic          clk;
    logic          reset;
    logic [W-1:0]  pipe_w;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic [W-1:0]  w;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          busy1;
    logic          busy2;
    logic [2:0]    count;

    // Reference model: the queue holds {live, addr, data} per pending result.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w_exp;
    logic         m_acc;

    int checks;
    int failures;

    wb_merge #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_w    (pipe_w),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .w         (w),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_busy(input logic [AW-1:0] ra);
        logic b;
        b = 1'b0;
        if (ra != '0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i][W-1] && (exp_q[i][W-2:DW] == ra)) b = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic drive(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        pipe_w    = {pe, pa, pd};
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
    endtask

    // One clock: check combinational outputs against the model, advance the
    // model by the priority rules, then check the registered write.
    task automatic cycle();
        logic [W-1:0]  h;
        logic [W-1:0]  t;
        logic          own;
        logic          acc;
        logic          was_empty;
        logic          byp;
        logic          p_en;
        logic [AW-1:0] p_a;
        #1;
        check("mdu_ready", mdu_ready, exp_q.size() < DEPTH);
        check("busy1", busy1, model_busy(ra1));
        check("busy2", busy2, model_busy(ra2));
        check("count", count, exp_q.size());
        p_en      = pipe_w[W-1];
        p_a       = pipe_w[W-2:DW];
        own       = p_en && (p_a != '0);
        acc       = mdu_valid && (exp_q.size() < DEPTH);
        m_acc     = acc;
        was_empty = (exp_q.size() == 0);
        byp       = 1'b0;
        if (own) begin
            foreach (exp_q[i]) begin
                if (exp_q[i][W-2:DW] == p_a) begin
                    t = exp_q[i];
                    t[W-1] = 1'b0;
                    exp_q[i] = t;
                end
            end
            w_exp = pipe_w;
        end else if (!was_empty) begin
            h = exp_q.pop_front();
            w_exp = h[W-1] ? h : '0;
        end else if (acc && (mdu_addr != '0)) begin
            w_exp = {1'b1, mdu_addr, mdu_data};
            byp = 1'b1;
        end else begin
            w_exp = '0;
        end
        if (acc && (mdu_addr != '0) && !byp) begin
            exp_q.push_back({!(own && (mdu_addr == p_a)), mdu_addr, mdu_data});
        end
        @(posedge clk);
        #1;
        check("w_en", w[W-1], w_exp[W-1]);
        if (w_exp[W-1]) check("w", w, w_exp);
    endtask

    initial begin
        logic [W-1:0] hold_w;
        checks   = 0;
        failures = 0;
        m_acc    = 1'b0;
        w_exp    = '0;
        reset    = 1'b0;
        ra1      = 5'd3;
        ra2      = 5'd9;
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset state
        #2;
        check("rst_w", w, 0);
        check("rst_count", count, 0);
        check("rst_ready", mdu_ready, 1);
        check("rst_busy1", busy1, 0);
        check("rst_busy2", busy2, 0);
        #10;
        reset = 1'b1;

        // Pipeline write passes through with one cycle latency
        drive(1'b1, 5'd5, 32'hAAAA, 1'b0, '0, '0);
        cycle();
        check("t1_w", w, {1'b1, 5'd5, 32'hAAAA});
        check("t1_count", count, 0);

        // Bypass: idle pipe, empty FIFO
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234);
        cycle();
        check("t2_w", w, {1'b1, 5'd7, 32'h1234});
        check("t2_count", count, 0);

        // Fill under a busy pipeline, then drain in order
        ra1 = 5'd3;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd20, $urandom, 1'b1, AW'(k), 32'h100 + k);
            cycle();
        end
        check("t3_count_full", count, 4);
        check("t3_busy_r3", busy1, 1);
        check("t3_ready_full", mdu_ready, 0);
        drive(1'b1, 5'd20, 32'h5555, 1'b1, 5'd5, 32'h105);
        cycle();
        cycle();
        check("t3_still_full", count, 4);
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h105);
        cycle();
        check("t3_w1", w, {1'b1, 5'd1, 32'h101});
        check("t3_count_pop", count, 3);
        check("t3_ready_rise", mdu_ready, 1);
        cycle();
        check("t3_w2", w, {1'b1, 5'd2, 32'h102});
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 3; k <= 5; k++) begin
            cycle();
            check("t3_wk", w, {1'b1, AW'(k), 32'h100 + k});
        end
        cycle();
        check("t3_drained", count, 0);

        // Squash of a queued entry by a later pipeline write
        ra1 = 5'd9;
        drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd9, 32'h9999);
        cycle();
        check("t4_busy_before", busy1, 1);
        drive(1'b1, 5'd9, 32'hBEEF, 1'b0, '0, '0);
        cycle();
        check("t4_w", w, {1'b1, 5'd9, 32'hBEEF});
        check("t4_busy_after", busy1, 0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();
        check("t4_dead_pop", w[W-1], 0);
        check("t4_count", count, 0);

        // Same-cycle collision: mdu result enqueued dead
        ra1 = 5'd4;
        drive(1'b1, 5'd4, 32'h11111111, 1'b1, 5'd4, 32'h22222222);
        cycle();
        check("t5_w", w, {1'b1, 5'd4, 32'h11111111});
        check("t5_count", count, 1);
        check("t5_busy", busy1, 0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();
        check("t5_dead_pop", w[W-1], 0);

        // Asynchronous reset with three entries queued
        ra1 = 5'd11;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd20, 32'h7, 1'b1, AW'(10 + k), 32'hC0 + k);
            cycle();
        end
        check("t6_count_pre", count, 3);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset = 1'b0;
        #2;
        check("t6_count", count, 0);
        check("t6_w", w, 0);
        check("t6_ready", mdu_ready, 1);
        check("t6_busy", busy1, 0);
        exp_q.delete();
        w_exp = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        // Randomized traffic; a stalled producer holds its result
        hold_w = '0;
        for (int n = 0; n < 400; n++) begin
            ra1 = AW'($urandom_range(0, 7));
            ra2 = AW'($urandom_range(0, 7));
            pipe_w = {($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                      AW'($urandom_range(0, 7)), DW'($urandom)};
            if (!(mdu_valid && !m_acc)) begin
                mdu_valid = ($urandom_range(0, 99) < 60);
                mdu_addr  = AW'($urandom_range(0, 7));
                mdu_data  = DW'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback-side merge unit that sits directly upstream of the register file write port.
- Combines the in-order pipeline writeback stream with out-of-order results from the multi-cycle unit (mul/div, long loads) onto the single w_rf_t write port.
- The pipeline always has priority. Multi-cycle results queue in a small FIFO and drain into idle write slots.
- Exports per-register busy flags so decode can stall on pending queued writes.

Parameters:
- DEPTH, 4, number of FIFO entries for multi-cycle results (power of two, >=2).
- AW, 5, register address width (creg_addr_t).
- DW, 32, data width (word_t).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_w  in  1+AW+DW  pipeline writeback request (w_rf_t: en, addr, wd); always accepted, never stalled.
- mdu_valid  in  1  multi-cycle result valid.
- mdu_addr  in  AW  destination register of the multi-cycle result.
- mdu_data  in  DW  multi-cycle result data.
- mdu_ready  out  1  FIFO can accept a result this cycle.
- w  out  1+AW+DW  registered write request to the regfile (w_rf_t).
- ra1  in  AW  decode source address 1 for the busy query.
- ra2  in  AW  decode source address 2 for the busy query.
- busy1  out  1  a live queued write targets ra1.
- busy2  out  1  a live queued write targets ra2.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0, asynchronous): w cleared to all zeros (w.en=0), FIFO emptied, head and tail pointers 0, all live bits 0, count=0. Consequently mdu_ready=1, busy1=busy2=0.
- Acceptance:
  - mdu_ready = (count < DEPTH), derived from registered state only; it does not depend on a same-cycle pop.
  - A transfer occurs when mdu_valid && mdu_ready. mdu_valid while not ready is ignored; the producer must hold its result.
  - A transfer with mdu_addr==0 is accepted and discarded (no enqueue, no write).
- Pipeline slot: the pipeline owns the slot when pipe_w.en && pipe_w.addr!=0. A pipe_w request with addr==0 is treated as idle.
- Next w, one-cycle latency, priority order:
  1. Pipeline owns slot: w <= pipe_w.
  2. Else FIFO non-empty: pop the head. If the head is live, w <= {1, head.addr, head.data}; if dead, w.en <= 0.
  3. Else FIFO empty and an accepted mdu transfer with addr!=0 is present (bypass): w <= {1, mdu_addr, mdu_data}; nothing is enqueued.
  4. Else w.en <= 0. The addr/wd fields of w are don't-care when en=0 but are reset to 0.
- Enqueue: an accepted mdu transfer not consumed by the bypass path is written at the tail with live=1.
  - Simultaneous push and pop are allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Squash (WAW ordering): any pipeline write to addr A is architecturally younger than every multi-cycle result present in the same cycle. On a pipeline write:
  - every FIFO entry with addr==A has live cleared, including the head being popped and the entry enqueued that cycle;
  - a same-cycle mdu transfer to A is enqueued dead, and is never bypassed.
  - A dead entry still occupies its slot and pops in a free slot without writing.
- Busy query (combinational):
  - busyN = OR over live entries of (entry.addr==raN).
  - busyN is forced to 0 when raN==0.
  - The w register and the incoming mdu transfer are excluded; the regfile bypasses the in-flight w.
- Boundaries:
  - Full FIFO with pipeline writing every cycle: no pop, and mdu_ready stays 0 until the first idle slot.
  - Full FIFO with a pop: mdu_ready stays 0 in that cycle; it rises the next cycle.
  - Reset asserted mid-operation discards all queued entries without writing them.

Test Plan:
- Reset, then pipe_w={1,5,32'hAAAA} -> next cycle w={1,5,32'hAAAA}; mdu_ready=1, busy=0, count=0.
- Pipe idle, FIFO empty, mdu {valid, addr=7, 32'h1234} -> next cycle w={1,7,32'h1234}, count stays 0 (bypass).
- Pipe writing every cycle while mdu pushes regs 1,2,3,4,5 -> four accepted, mdu_ready=0 on the 5th, count=4, busy1=1 for ra1=3. Pipe goes idle -> w writes 1,2,3,4 in order on consecutive cycles; reg 5 is accepted once count<4.
- FIFO holds live entry for reg 9; pipe_w={1,9,32'hBEEF} -> w={1,9,32'hBEEF}, busy(ra=9)=0. The dead entry later pops with w.en=0, and reg 9 is never overwritten.
- Same cycle: pipe_w={1,4,X} and mdu {valid, addr=4, Y} -> w writes X; Y is enqueued dead and never reaches w.
- Reset pulsed low with count=3 -> count=0, w.en=0 immediately (asynchronous); none of the queued entries is written after reset releases.
